pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- XLEN, 32, PC/address width; SHALL be >= 32.
- RESET_VEC, 0, PC value after reset.
- EXC_VEC, 32'h0000_0180 zero-extended to XLEN, exception handler address.
- RAS_DEPTH, 4, return-address-stack entries; SHALL be a power of 2, >= 2.

REQ-002 Ports, one per line (name, direction, width, meaning):
- CLK, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-high reset.
- stall, in, 1, hold all state.
- exc, in, 1, take exception.
- eret, in, 1, return from exception.
- jr, in, 1, register-indirect jump.
- jr_ret, in, 1, qualifies jr as a subroutine return.
- jr_addr, in, XLEN, jr target from the register file.
- jump, in, 1, J/JAL.
- link, in, 1, qualifies jump as JAL.
- j_addr, in, XLEN, jump target; only bits [27:0] are used.
- Zero, in, 1, ALU zero flag.
- Branch, in, 1, conditional-branch instruction.
- PCWrite, in, 1, unconditional ALU-computed redirect.
- Aluaddr, in, XLEN, branch/redirect target.
- PC, out, XLEN, current fetch address, registered.
- epc, out, XLEN, exception PC, registered.
- ras_count, out, clog2(RAS_DEPTH)+1, valid stack entries.
- redirect, out, 1, registered; high for one cycle after any non-sequential PC update.
- pc_misaligned, out, 1, combinational; equals PC[1:0] != 0.

Function
REQ-003 PC SHALL change only on the rising edge of CLK or on reset.
REQ-004 With stall=1 and exc=0, PC, epc, RAS, and ras_count SHALL hold. All other requests SHALL be dropped. redirect SHALL be 0.
REQ-005 With stall=0, or exc=1, next PC SHALL be chosen by strict priority:
1. exc: EXC_VEC
2. eret: epc
3. jr: RAS top if jr_ret=1 and ras_count>0; otherwise jr_addr
4. jump: {PC[XLEN-1:28], j_addr[27:0]}
5. Zero&Branch or PCWrite: Aluaddr
6. none: PC+4
REQ-006 PC+4 SHALL wrap modulo 2^XLEN. There is no carry out and no error.
REQ-007 exc SHALL be taken even when stall=1. The same edge SHALL do all of the following:
- epc <= current PC
- ras_count <= 0
- PC <= EXC_VEC
REQ-008 epc SHALL change only on exc.
REQ-009 RAS push: a selected jump with link=1 SHALL push PC+4 (wrapped). ras_count SHALL increment, saturating at RAS_DEPTH.
REQ-010 Push when full: the push SHALL overwrite the oldest entry through a circular top pointer. ras_count SHALL stay at RAS_DEPTH.
REQ-011 RAS pop: a selected jr with jr_ret=1 and ras_count>0 SHALL use the top entry as the target and decrement ras_count.
REQ-012 Pop when empty: the target SHALL be jr_addr and ras_count SHALL stay 0.
REQ-013 jr with jr_ret=0 SHALL use jr_addr and SHALL leave the RAS unchanged.
REQ-014 Only the selected source SHALL affect the RAS. Because of the priority, push and pop never occur on the same edge.
REQ-015 redirect SHALL be 1 in the cycle after any edge where a source other than PC+4 was selected. This includes a taken branch whose target equals PC+4.
REQ-016 A misaligned PC SHALL be fetched as-is. It SHALL only be flagged on pc_misaligned.
REQ-017 Inputs are sampled only at clock edges. There is no internal combinational path from inputs to PC.

Reset
REQ-018 While reset=1, with no clock required, the outputs SHALL be forced as follows:
- PC = RESET_VEC
- epc = 0
- ras_count = 0
- redirect = 0
RAS entry contents are don't-care.
REQ-019 Reset asserted mid-operation, including during stall or exc, SHALL override everything. The first edge after deassertion SHALL follow REQ-005 from RESET_VEC.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Sequential and wrap: reset, then 3 idle edges -> PC 0,4,8,C. Then force PC to FFFF_FFFC via Aluaddr/PCWrite; next idle edge -> PC 0, redirect 0.
- Priority: at PC=0x100, in one edge assert exc, eret, jr, jump, Branch&Zero, and PCWrite -> PC=0x180, epc=0x100, ras_count 0, redirect 1. Then eret alone -> PC=0x100.
- Jump and branch targets:
  - PC=0x3000_0010, jump, j_addr=0x0ABC_DEF0 -> PC=0x3ABC_DEF0.
  - Branch=1, Zero=0 -> PC+4.
  - Branch=1, Zero=1, Aluaddr=0x40 -> PC=0x40.
- RAS (RAS_DEPTH=4):
  - 5 JALs at PCs 0x10,0x20,0x30,0x40,0x50 -> ras_count 4.
  - Then 5 returns, jr_addr=0xDEAD_0000 -> PC 0x54,0x44,0x34,0x24, then 0xDEAD_0000; ras_count 3,2,1,0,0.
- Stall and reset:
  - stall=1 with jump=1 for 3 edges -> PC unchanged, redirect 0.
  - stall=1 with exc=1 -> PC=0x180.
  - Assert reset between edges -> PC=RESET_VEC immediately, ras_count 0.
- Parameter sweep: XLEN=64, RESET_VEC=0x1000, RAS_DEPTH=2 -> reset gives PC=0x1000. Upper 36 bits are preserved across a jump. Third push evicts the oldest entry.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection, exception entry/return,
// and a circular return-address stack that predicts subroutine returns.
module pc_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h0000_0180),
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         exc,
    input  logic                         eret,
    input  logic                         jr,
    input  logic                         jr_ret,
    input  logic [XLEN-1:0]              jr_addr,
    input  logic                         jump,
    input  logic                         link,
    input  logic [XLEN-1:0]              j_addr,
    input  logic                         Zero,
    input  logic                         Branch,
    input  logic                         PCWrite,
    input  logic [XLEN-1:0]              Aluaddr,
    output logic [XLEN-1:0]              PC,
    output logic [XLEN-1:0]              epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         redirect,
    output logic                         pc_misaligned
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  epc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0] top_r;
    logic             redirect_r;
    logic [XLEN-1:0]  ras_r [RAS_DEPTH];

    logic [XLEN-1:0]  seq_pc_s;
    logic [XLEN-1:0]  nxt_pc_s;
    logic [PTR_W-1:0] push_ptr_s;
    logic             take_s;
    logic             push_s;
    logic             pop_s;
    logic             unused_s;

    // Only the low 28 bits of a J/JAL target are architecturally meaningful.
    assign unused_s   = ^j_addr[XLEN-1:28];
    assign seq_pc_s   = pc_r + XLEN'(4);
    assign push_ptr_s = top_r + PTR_W'(1);

    // Strict-priority next-PC selection; exc wins even over stall.
    always_comb begin
        nxt_pc_s = seq_pc_s;
        take_s   = 1'b0;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        if (exc) begin
            nxt_pc_s = EXC_VEC;
            take_s   = 1'b1;
        end else if (stall) begin
            nxt_pc_s = pc_r;
        end else if (eret) begin
            nxt_pc_s = epc_r;
            take_s   = 1'b1;
        end else if (jr) begin
            take_s = 1'b1;
            if (jr_ret && (cnt_r != CNT_W'(0))) begin
                nxt_pc_s = ras_r[top_r];
                pop_s    = 1'b1;
            end else begin
                nxt_pc_s = jr_addr;
            end
        end else if (jump) begin
            nxt_pc_s = {pc_r[XLEN-1:28], j_addr[27:0]};
            take_s   = 1'b1;
            push_s   = link;
        end else if ((Zero && Branch) || PCWrite) begin
            nxt_pc_s = Aluaddr;
            take_s   = 1'b1;
        end else begin
            nxt_pc_s = seq_pc_s;
        end
    end

    // PC, EPC, stack bookkeeping and the one-cycle redirect flag.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pc_r       <= RESET_VEC;
            epc_r      <= '0;
            cnt_r      <= '0;
            top_r      <= '0;
            redirect_r <= 1'b0;
        end else begin
            pc_r       <= nxt_pc_s;
            redirect_r <= take_s;
            if (exc) begin
                epc_r <= pc_r;
                cnt_r <= '0;
            end else if (push_s) begin
                // Full stack keeps its count; the wrapped pointer overwrites the oldest entry.
                top_r <= push_ptr_s;
                if (cnt_r != CNT_W'(RAS_DEPTH)) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else if (pop_s) begin
                top_r <= top_r - PTR_W'(1);
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    // Stack storage carries no reset; entries are only read while counted valid.
    always_ff @(posedge CLK) begin
        if (push_s && !reset) begin
            ras_r[push_ptr_s] <= seq_pc_s;
        end
    end

    assign PC            = pc_r;
    assign epc           = epc_r;
    assign ras_count     = cnt_r;
    assign redirect      = redirect_r;
    assign pc_misaligned = (pc_r[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench: default 32-bit instance plus a 64-bit, depth-2 instance.
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 32-bit instance signals
    logic        reset;
    logic        stall, exc, eret, jr, jr_ret, jump, link, zero, branch, pcwrite;
    logic [31:0] jr_addr, j_addr, aluaddr;
    logic [31:0] pc, epc;
    logic [2:0]  ras_count;
    logic        redirect, pc_misaligned;

    // 64-bit instance signals
    logic        rst_b;
    logic        b_stall, b_exc, b_eret, b_jr, b_jr_ret, b_jump, b_link, b_zero, b_branch, b_pcwrite;
    logic [63:0] b_jr_addr, b_j_addr, b_aluaddr;
    logic [63:0] b_pc, b_epc;
    logic [1:0]  b_ras_count;
    logic        b_redirect, b_pc_misaligned;

    pc_sequencer dut (
        .CLK(clk), .reset(reset), .stall(stall), .exc(exc), .eret(eret),
        .jr(jr), .jr_ret(jr_ret), .jr_addr(jr_addr), .jump(jump), .link(link),
        .j_addr(j_addr), .Zero(zero), .Branch(branch), .PCWrite(pcwrite),
        .Aluaddr(aluaddr), .PC(pc), .epc(epc), .ras_count(ras_count),
        .redirect(redirect), .pc_misaligned(pc_misaligned)
    );

    pc_sequencer #(
        .XLEN(64), .RESET_VEC(64'h1000), .RAS_DEPTH(2)
    ) dut_b (
        .CLK(clk), .reset(rst_b), .stall(b_stall), .exc(b_exc), .eret(b_eret),
        .jr(b_jr), .jr_ret(b_jr_ret), .jr_addr(b_jr_addr), .jump(b_jump), .link(b_link),
        .j_addr(b_j_addr), .Zero(b_zero), .Branch(b_branch), .PCWrite(b_pcwrite),
        .Aluaddr(b_aluaddr), .PC(b_pc), .epc(b_epc), .ras_count(b_ras_count),
        .redirect(b_redirect), .pc_misaligned(b_pc_misaligned)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_a();
        stall = 1'b0; exc = 1'b0; eret = 1'b0; jr = 1'b0; jr_ret = 1'b0;
        jump = 1'b0; link = 1'b0; zero = 1'b0; branch = 1'b0; pcwrite = 1'b0;
        jr_addr = 32'h0; j_addr = 32'h0; aluaddr = 32'h0;
    endtask

    task automatic clr_b();
        b_stall = 1'b0; b_exc = 1'b0; b_eret = 1'b0; b_jr = 1'b0; b_jr_ret = 1'b0;
        b_jump = 1'b0; b_link = 1'b0; b_zero = 1'b0; b_branch = 1'b0; b_pcwrite = 1'b0;
        b_jr_addr = 64'h0; b_j_addr = 64'h0; b_aluaddr = 64'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_a(input logic [31:0] target);
        clr_a(); pcwrite = 1'b1; aluaddr = target;
        step();
        clr_a();
    endtask

    logic [31:0] ret_exp [5];
    logic [2:0]  cnt_exp [5];

    initial begin
        reset = 1'b1; rst_b = 1'b1;
        clr_a(); clr_b();
        #1;
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_epc", 64'(epc), 64'h0);
        check("rst_cnt", 64'(ras_count), 64'h0);
        check("rst_redir", 64'(redirect), 64'h0);
        check("rst_b_pc", b_pc, 64'h1000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Sequential fetch and wrap
        step(); check("seq_4", 64'(pc), 64'h4);
        step(); check("seq_8", 64'(pc), 64'h8);
        step(); check("seq_c", 64'(pc), 64'hC);
        check("seq_redir", 64'(redirect), 64'h0);
        check("aligned", 64'(pc_misaligned), 64'h0);
        goto_a(32'hFFFF_FFFC);
        check("force_pc", 64'(pc), 64'hFFFF_FFFC);
        check("force_redir", 64'(redirect), 64'h1);
        step();
        check("wrap_pc", 64'(pc), 64'h0);
        check("wrap_redir", 64'(redirect), 64'h0);

        // Priority: everything asserted at once, exception wins
        goto_a(32'h100);
        exc = 1'b1; eret = 1'b1; jr = 1'b1; jr_ret = 1'b1; jr_addr = 32'h900;
        jump = 1'b1; link = 1'b1; j_addr = 32'h700; branch = 1'b1; zero = 1'b1;
        pcwrite = 1'b1; aluaddr = 32'h500;
        step(); clr_a();
        check("prio_pc", 64'(pc), 64'h180);
        check("prio_epc", 64'(epc), 64'h100);
        check("prio_cnt", 64'(ras_count), 64'h0);
        check("prio_redir", 64'(redirect), 64'h1);
        eret = 1'b1;
        step(); clr_a();
        check("eret_pc", 64'(pc), 64'h100);
        check("eret_epc", 64'(epc), 64'h100);

        // Jump and branch targets
        goto_a(32'h3000_0010);
        jump = 1'b1; j_addr = 32'h0ABC_DEF0;
        step(); clr_a();
        check("jump_pc", 64'(pc), 64'h3ABC_DEF0);
        check("jump_nolink_cnt", 64'(ras_count), 64'h0);
        branch = 1'b1; zero = 1'b0; aluaddr = 32'h40;
        step(); clr_a();
        check("br_nt_pc", 64'(pc), 64'h3ABC_DEF4);
        check("br_nt_redir", 64'(redirect), 64'h0);
        branch = 1'b1; zero = 1'b1; aluaddr = 32'h40;
        step(); clr_a();
        check("br_t_pc", 64'(pc), 64'h40);
        check("br_t_redir", 64'(redirect), 64'h1);

        // RAS: five calls into a four-deep stack
        for (int i = 0; i < 5; i++) begin
            goto_a(32'((i + 1) * 16));
            jump = 1'b1; link = 1'b1; j_addr = 32'h200;
            step(); clr_a();
            check("jal_pc", 64'(pc), 64'h200);
            check("jal_cnt", 64'(ras_count), 64'((i < 3) ? i + 1 : 4));
        end
        jr = 1'b1; jr_ret = 1'b0; jr_addr = 32'h500;
        step(); clr_a();
        check("jr_plain_pc", 64'(pc), 64'h500);
        check("jr_plain_cnt", 64'(ras_count), 64'h4);
        ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24, 32'hDEAD_0000};
        cnt_exp = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 5; i++) begin
            jr = 1'b1; jr_ret = 1'b1; jr_addr = 32'hDEAD_0000;
            step(); clr_a();
            check("ret_pc", 64'(pc), 64'(ret_exp[i]));
            check("ret_cnt", 64'(ras_count), 64'(cnt_exp[i]));
        end
        branch = 1'b1; zero = 1'b1; aluaddr = 32'hDEAD_0004;
        step(); clr_a();
        check("br_seq_pc", 64'(pc), 64'hDEAD_0004);
        check("br_seq_redir", 64'(redirect), 64'h1);

        // Stall holds state and drops requests
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; jump = 1'b1; link = 1'b1; j_addr = 32'h0FFF_0000;
            step();
            check("stall_pc", 64'(pc), 64'hDEAD_0004);
            check("stall_redir", 64'(redirect), 64'h0);
            check("stall_cnt", 64'(ras_count), 64'h0);
        end
        clr_a();
        stall = 1'b1; exc = 1'b1;
        step(); clr_a();
        check("stall_exc_pc", 64'(pc), 64'h180);
        check("stall_exc_epc", 64'(epc), 64'hDEAD_0004);
        check("stall_exc_redir", 64'(redirect), 64'h1);
        step();
        check("post_exc_pc", 64'(pc), 64'h184);

        // Reset between edges, during stall and exc
        goto_a(32'h60);
        jump = 1'b1; link = 1'b1; j_addr = 32'h80;
        step(); clr_a();
        check("pre_rst_cnt", 64'(ras_count), 64'h1);
        stall = 1'b1; exc = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_pc", 64'(pc), 64'h0);
        check("mid_rst_cnt", 64'(ras_count), 64'h0);
        check("mid_rst_epc", 64'(epc), 64'h0);
        check("mid_rst_redir", 64'(redirect), 64'h0);
        #1 reset = 1'b0;
        clr_a();
        step();
        check("after_rst_pc", 64'(pc), 64'h4);

        // Misaligned fetch continues, only flagged
        goto_a(32'h102);
        check("misal_pc", 64'(pc), 64'h102);
        check("misal_flag", 64'(pc_misaligned), 64'h1);
        step();
        check("misal_seq_pc", 64'(pc), 64'h106);

        // 64-bit, depth-2 instance
        rst_b = 1'b0;
        b_pcwrite = 1'b1; b_aluaddr = 64'hABCD_EF12_3000_0000;
        step(); clr_b();
        b_jump = 1'b1; b_link = 1'b1; b_j_addr = 64'hFFFF_FFFF_0111_1110;
        step();
        check("b_jump_pc", b_pc, 64'hABCD_EF12_3111_1110);
        check("b_cnt1", 64'(b_ras_count), 64'h1);
        b_j_addr = 64'h0000_0000_0222_2220;
        step();
        check("b_cnt2", 64'(b_ras_count), 64'h2);
        b_j_addr = 64'h0000_0000_0333_3330;
        step(); clr_b();
        check("b_jump3_pc", b_pc, 64'hABCD_EF12_3333_3330);
        check("b_cnt_sat", 64'(b_ras_count), 64'h2);
        b_jr = 1'b1; b_jr_ret = 1'b1; b_jr_addr = 64'h5555;
        step();
        check("b_ret1", b_pc, 64'hABCD_EF12_3222_2224);
        step();
        check("b_ret2", b_pc, 64'hABCD_EF12_3111_1114);
        check("b_ret2_cnt", 64'(b_ras_count), 64'h0);
        step(); clr_b();
        check("b_ret3_evicted", b_pc, 64'h5555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
